// File: rtl/x_mem_arb.sv
// rtl/x_mem_arb.sv - two-master round-robin arbiter for one rv32i-style memory port
// Optional grant watchdog with o_timeout: define X_MEM_ARB_WATCHDOG_EN.
module x_mem_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_a_valid,
    input  logic          i_a_rnw,
    input  logic [AW-1:0] i_a_addr,
    input  logic [DW-1:0] i_a_data,
    output logic          o_a_accept,
    output logic [DW-1:0] o_a_data,
    input  logic          i_b_valid,
    input  logic          i_b_rnw,
    input  logic [AW-1:0] i_b_addr,
    input  logic [DW-1:0] i_b_data,
    output logic          o_b_accept,
    output logic [DW-1:0] o_b_data,
    output logic          o_valid,
    output logic          o_rnw,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data,
    input  logic          i_accept,
    input  logic [DW-1:0] i_data,
`ifdef X_MEM_ARB_WATCHDOG_EN
    output logic          o_timeout,
`endif
    output logic [1:0]    o_grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t r_state;
    logic   r_prio_b;

    logic w_own_a;
    logic w_own_b;
    logic w_own_valid;
    logic w_done;
    logic w_timeout;
    logic w_end;

    assign w_own_a     = (r_state == GNT_A);
    assign w_own_b     = (r_state == GNT_B);
    assign w_own_valid = (w_own_a & i_a_valid) | (w_own_b & i_b_valid);
    assign w_done      = w_own_valid & i_accept;

`ifdef X_MEM_ARB_WATCHDOG_EN
    localparam logic [7:0] LP_WD_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_wd_cnt;

    // A real accept on the limit cycle takes precedence over the forced completion.
    assign w_timeout = w_own_valid & ~i_accept & (r_wd_cnt == LP_WD_LAST);
    assign o_timeout = w_timeout;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)
            r_wd_cnt <= 8'd0;
        else if (r_state == IDLE)
            r_wd_cnt <= 8'd0;
        else
            r_wd_cnt <= r_wd_cnt + 8'd1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_end = w_done | w_timeout;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state  <= IDLE;
            r_prio_b <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_a_valid && (!i_b_valid || !r_prio_b))
                        r_state <= GNT_A;
                    else if (i_b_valid)
                        r_state <= GNT_B;
                end
                GNT_A, GNT_B: begin
                    // A dropped request is a protocol violation: release without touching priority.
                    if (!w_own_valid) begin
                        r_state <= IDLE;
                    end else if (w_end) begin
                        r_state  <= IDLE;
                        r_prio_b <= w_own_a;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_valid    = w_own_valid & ~w_timeout;
    assign o_rnw      = w_own_a ? i_a_rnw  : (w_own_b ? i_b_rnw  : 1'b0);
    assign o_addr     = w_own_a ? i_a_addr : (w_own_b ? i_b_addr : '0);
    assign o_data     = w_own_a ? i_a_data : (w_own_b ? i_b_data : '0);
    assign o_grant    = {w_own_b, w_own_a};
    assign o_a_accept = w_own_a & w_end;
    assign o_b_accept = w_own_b & w_end;
    assign o_a_data   = (w_own_a & w_done)    ? i_data :
                        (w_own_a & w_timeout) ? DW'(32'hDEAD_BEEF) : '0;
    assign o_b_data   = (w_own_b & w_done)    ? i_data :
                        (w_own_b & w_timeout) ? DW'(32'hDEAD_BEEF) : '0;

endmodule
